baccarat_monitor: RTL
=====================

// Module: baccarat_monitor
// PURPOSE
// Observing end of the task5 board interface. Samples HEX5..HEX0 and LEDR after every
// step press and decodes the seven-segment glyphs back to card ranks. Recomputes both
// hand scores, checks them against LEDR, and keeps win/loss/tie tallies.
// Synthesizable; sits beside the game on CLOCK_50 for on-board self-check and bench scoring.
// PARAMETERS
// SETTLE  default 4   CLOCK_50 cycles from detected step rise to display capture (>=1)
// CNT_W   default 8   width of each result counter; counters saturate at 2**CNT_W-1
// PORTS
// CLOCK_50      in   1        sole clock
// reset         in   1        asynchronous, active-high; clears all state
// step          in   1        game's slow-clock/KEY level, asynchronous to CLOCK_50
// HEX5..HEX0    in   7 each   active-low {g,f,e,d,c,b,a}; HEX2..0 player cards 3..1, HEX5..3 dealer cards 3..1
// LEDR          in   10       [3:0] player score, [7:4] dealer score, [8] player win, [9] dealer win
// pcard1..3     out  4 each   decoded player ranks (0=no card, 1..13)
// dcard1..3     out  4 each   decoded dealer ranks
// cap_valid     out  1        one-cycle pulse: card outputs updated this cycle
// round_done    out  1        one-cycle pulse: a result was tallied
// player_wins   out  CNT_W    LEDR[9:8]==2'b01 tally
// dealer_wins   out  CNT_W    LEDR[9:8]==2'b10 tally
// ties          out  CNT_W    LEDR[9:8]==2'b11 tally
// seg_err       out  1        sticky: an undecodable glyph was captured
// score_err     out  1        sticky: recomputed score != LEDR score
// BEHAVIOUR
// - Reset (async, any time, including mid-capture): all outputs 0; FSM to IDLE; synchroniser,
//   edge detector and result-armed flag cleared (armed=1 after reset).
// - step passes through a 2-FF synchroniser. A rise is a 0->1 change between sync stage 2 and its delayed copy.
// - Glyph table (active-low): 1111111=0(blank) 0001000=1(A) 0100100=2 0110000=3 0011001=4 0010010=5
//   0000010=6 1111000=7 0000000=8 0010000=9 1000000=10 1100001=11(J) 0011000=12(q) 0001001=13(K).
//   Any other pattern decodes to 0 and sets seg_err.
// - FSM: IDLE --rise--> SETTLE (count SETTLE-1..0) --0--> CAPTURE --> CHECK --> IDLE.
//   A rise seen outside IDLE is ignored (no queueing).
// - CAPTURE (rise cycle t, CAPTURE at t+SETTLE): register all six decodes and LEDR snapshot.
//   Card outputs and cap_valid=1 are visible at t+SETTLE+1.
// - CHECK (t+SETTLE+1): card value = rank if rank<=9, else 0.
//   Hand score = (v1+v2+v3) mod 10, 5-bit sum, sum<=27.
//   If LEDR_snap[9:8]!=0, compare hand scores to LEDR_snap[3:0] and [7:4]; mismatch sets score_err,
//   visible at t+SETTLE+2. No score check while LEDR_snap[9:8]==0, because scores may lag mid-deal.
// - Tally: in CHECK, if LEDR_snap[9:8]!=0 and armed, increment the matching counter, pulse round_done
//   (visible t+SETTLE+2) and clear armed. armed is set again whenever a capture sees LEDR[9:8]==0.
//   A result held across several steps therefore counts once.
// - Counters saturate; at max, round_done still pulses and the counter holds.
// - seg_err and score_err clear only on reset.
// TESTING
// 1) reset=1 then 0, no step -> all outputs 0; cap_valid never pulses.
// 2) HEX0=0001000, HEX1=0000000, HEX3=1100001, HEX4=0010010, others blank, LEDR=0; step 0->1
//    -> cap_valid pulse; pcard1=1, pcard2=8, dcard1=11, dcard2=5; no errors, no round_done.
// 3) Same cards, LEDR={2'b01,4'd5,4'd9}; step -> round_done, player_wins=1.
//    A second step with LEDR unchanged -> no increment.
// 4) LEDR[3:0]=4'd7 while the player hand sums to 9 and LEDR[9:8]=2'b10 -> score_err=1, dealer_wins=1.
//    score_err stays 1 through later clean rounds.
// 5) HEX2=1010101 -> pcard3=0, seg_err=1.
//    Assert reset during SETTLE -> seg_err/counters 0, FSM idle, next step captures normally.
// 6) CNT_W=2: four tie rounds, each separated by a LEDR=0 capture -> ties saturates at 3; round_done pulses 4 times.

Source files
------------

// File: rtl/baccarat_monitor.sv
// rtl/baccarat_monitor.sv - decodes the task5 HEX/LEDR display after each step, re-scores both hands and tallies results
module baccarat_monitor #(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             step,
  input  logic [6:0]       HEX5,
  input  logic [6:0]       HEX4,
  input  logic [6:0]       HEX3,
  input  logic [6:0]       HEX2,
  input  logic [6:0]       HEX1,
  input  logic [6:0]       HEX0,
  input  logic [9:0]       LEDR,
  output logic [3:0]       pcard1,
  output logic [3:0]       pcard2,
  output logic [3:0]       pcard3,
  output logic [3:0]       dcard1,
  output logic [3:0]       dcard2,
  output logic [3:0]       dcard3,
  output logic             cap_valid,
  output logic             round_done,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties,
  output logic             seg_err,
  output logic             score_err
);

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_CHECK
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [SCW-1:0] settle_cnt;
  logic [SCW-1:0] settle_cnt_nx;

  logic           step_s1;
  logic           step_s2;
  logic           step_s2_d;
  logic           rise;

  logic           cap_en;
  logic           chk_en;

  logic [9:0]     led_snap;
  logic           armed;
  logic [4:0]     dec [6];
  logic           any_bad;

  logic [4:0]     psum;
  logic [4:0]     dsum;
  logic [3:0]     pscore;
  logic [3:0]     dscore;

  // Returns {undecodable, rank}; active-low segments ordered {g,f,e,d,c,b,a}.
  function automatic logic [4:0] seg_decode(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'b1111111: r = {1'b0, 4'd0};
      7'b0001000: r = {1'b0, 4'd1};
      7'b0100100: r = {1'b0, 4'd2};
      7'b0110000: r = {1'b0, 4'd3};
      7'b0011001: r = {1'b0, 4'd4};
      7'b0010010: r = {1'b0, 4'd5};
      7'b0000010: r = {1'b0, 4'd6};
      7'b1111000: r = {1'b0, 4'd7};
      7'b0000000: r = {1'b0, 4'd8};
      7'b0010000: r = {1'b0, 4'd9};
      7'b1000000: r = {1'b0, 4'd10};
      7'b1100001: r = {1'b0, 4'd11};
      7'b0011000: r = {1'b0, 4'd12};
      7'b0001001: r = {1'b0, 4'd13};
      default:    r = {1'b1, 4'd0};
    endcase
    return r;
  endfunction

  function automatic logic [4:0] card_val(input logic [3:0] rank);
    return (rank <= 4'd9) ? {1'b0, rank} : 5'd0;
  endfunction

  function automatic logic [3:0] mod10(input logic [4:0] s);
    logic [4:0] m;
    if (s >= 5'd20)
      m = s - 5'd20;
    else if (s >= 5'd10)
      m = s - 5'd10;
    else
      m = s;
    return m[3:0];
  endfunction

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      step_s1   <= 1'b0;
      step_s2   <= 1'b0;
      step_s2_d <= 1'b0;
    end else begin
      step_s1   <= step;
      step_s2   <= step_s1;
      step_s2_d <= step_s2;
    end
  end

  assign rise = step_s2 & ~step_s2_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_cnt_nx;
    end
  end

  // Rises outside IDLE are dropped; CAPTURE lands SETTLE cycles after the rise cycle.
  always_comb begin
    state_nx      = state;
    settle_cnt_nx = settle_cnt;
    case (state)
      S_IDLE: begin
        if (rise) begin
          if (SETTLE <= 1) begin
            state_nx = S_CAPTURE;
          end else begin
            state_nx      = S_SETTLE;
            settle_cnt_nx = SCW'(SETTLE - 1);
          end
        end
      end
      S_SETTLE: begin
        if (settle_cnt <= SCW'(1)) begin
          state_nx      = S_CAPTURE;
          settle_cnt_nx = '0;
        end else begin
          settle_cnt_nx = settle_cnt - SCW'(1);
        end
      end
      S_CAPTURE: state_nx = S_CHECK;
      S_CHECK:   state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cap_en = 1'b0;
    chk_en = 1'b0;
    case (state)
      S_CAPTURE: cap_en = 1'b1;
      S_CHECK:   chk_en = 1'b1;
      default: begin
        cap_en = 1'b0;
        chk_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    dec[0]  = seg_decode(HEX0);
    dec[1]  = seg_decode(HEX1);
    dec[2]  = seg_decode(HEX2);
    dec[3]  = seg_decode(HEX3);
    dec[4]  = seg_decode(HEX4);
    dec[5]  = seg_decode(HEX5);
    any_bad = dec[0][4] | dec[1][4] | dec[2][4] | dec[3][4] | dec[4][4] | dec[5][4];
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pcard1    <= 4'd0;
      pcard2    <= 4'd0;
      pcard3    <= 4'd0;
      dcard1    <= 4'd0;
      dcard2    <= 4'd0;
      dcard3    <= 4'd0;
      led_snap  <= 10'd0;
      cap_valid <= 1'b0;
      seg_err   <= 1'b0;
    end else begin
      cap_valid <= cap_en;
      if (cap_en) begin
        pcard1   <= dec[0][3:0];
        pcard2   <= dec[1][3:0];
        pcard3   <= dec[2][3:0];
        dcard1   <= dec[3][3:0];
        dcard2   <= dec[4][3:0];
        dcard3   <= dec[5][3:0];
        led_snap <= LEDR;
        if (any_bad)
          seg_err <= 1'b1;
      end
    end
  end

  // Face cards and tens count zero; the three-card sum never exceeds 27.
  always_comb begin
    psum   = card_val(pcard1) + card_val(pcard2) + card_val(pcard3);
    dsum   = card_val(dcard1) + card_val(dcard2) + card_val(dcard3);
    pscore = mod10(psum);
    dscore = mod10(dsum);
  end

  // armed makes a result that stays on LEDR across several steps count only once.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      round_done  <= 1'b0;
      player_wins <= '0;
      dealer_wins <= '0;
      ties        <= '0;
      score_err   <= 1'b0;
      armed       <= 1'b1;
    end else begin
      round_done <= 1'b0;
      if (chk_en) begin
        if (led_snap[9:8] == 2'b00) begin
          armed <= 1'b1;
        end else begin
          if (pscore != led_snap[3:0] || dscore != led_snap[7:4])
            score_err <= 1'b1;
          if (armed) begin
            armed      <= 1'b0;
            round_done <= 1'b1;
            case (led_snap[9:8])
              2'b01: if (player_wins != {CNT_W{1'b1}}) player_wins <= player_wins + CNT_W'(1);
              2'b10: if (dealer_wins != {CNT_W{1'b1}}) dealer_wins <= dealer_wins + CNT_W'(1);
              default: if (ties != {CNT_W{1'b1}}) ties <= ties + CNT_W'(1);
            endcase
          end
        end
      end
    end
  end

endmodule
